// File: rtl/dmux16_router_pkg.sv
// Shared word width, word type and channel-slice helper for the dmux16 router.
// Optional per-channel statistics are enabled with `define DMUX16_STATS_EN.
package dmux16_router_pkg;

  localparam int unsigned DMUX16_W = 16;

  typedef logic [DMUX16_W-1:0] word_t;

  // Low bit of channel k inside a packed NCH*DMUX16_W bus.
  function automatic int unsigned slice_lo(int unsigned k);
    return k * DMUX16_W;
  endfunction

endpackage

// File: rtl/dmux16_router_if.sv
// Producer/consumer bus of the dmux16 router; master = environment, slave = router.
// stat_cnt carries data only when DMUX16_STATS_EN is defined.
interface dmux16_router_if #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned SELW = 2
);
  import dmux16_router_pkg::*;

  word_t                    in_data;
  logic [SELW-1:0]          in_sel;
  logic                     in_valid;
  logic                     in_ready;
  logic [NCH*DMUX16_W-1:0]  out_data;
  logic [NCH-1:0]           out_valid;
  logic [NCH-1:0]           out_ready;
  logic [NCH*DMUX16_W-1:0]  stat_cnt;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, stat_cnt
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, stat_cnt
  );

endinterface

// File: rtl/dmux16_slot.sv
// One router channel: one-entry word register, valid flag, free term and
// an accept counter that exists only when DMUX16_STATS_EN is defined.
module dmux16_slot
  import dmux16_router_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  ready,
  input  word_t din,
  output word_t dout,
  output logic  valid,
  output logic  free,
  output word_t cnt
);

  assign free = ~valid | ready;

  // Load wins over pop, so a same-cycle pop+load keeps valid high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

`ifdef DMUX16_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= cnt + word_t'(1);
  end
`else
  assign cnt = '0;
`endif

endmodule

// File: rtl/dmux16_router.sv
// Routes one 16-bit word stream to NCH registered valid/ready channels by in_sel.
// Per-channel accept counters on stat_cnt when DMUX16_STATS_EN is defined.
module dmux16_router
  import dmux16_router_pkg::*;
#(
  parameter int unsigned NCH  = 4,
  parameter int unsigned SELW = 2
) (
  input logic           clk,
  input logic           rst_n,
  dmux16_router_if.slave bus
);

  logic [NCH-1:0] load;
  logic [NCH-1:0] free;
  logic           accept;

  assign bus.in_ready = rst_n & free[bus.in_sel];
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    load = '0;
    for (int unsigned k = 0; k < NCH; k++)
      load[k] = accept && (bus.in_sel == SELW'(k));
  end

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    dmux16_slot u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .ready (bus.out_ready[k]),
      .din   (bus.in_data),
      .dout  (bus.out_data[slice_lo(k) +: DMUX16_W]),
      .valid (bus.out_valid[k]),
      .free  (free[k]),
      .cnt   (bus.stat_cnt[slice_lo(k) +: DMUX16_W])
    );
  end

endmodule

// File: tb/tb_dmux16_router.sv
// Self-checking bench for dmux16_router: directed steps plus randomized traffic
// against a per-channel array model of the routing rules.
module tb_dmux16_router;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  dmux16_router_if #(.NCH(4), .SELW(2)) bus ();

  dmux16_router #(.NCH(4), .SELW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: one entry per channel.
  bit          mv[4];
  logic [15:0] md[4];
  logic [15:0] mc[4];
  bit          last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
      mc[i] = '0;
    end
  endtask

  // Applies the currently driven inputs for one clock and checks everything.
  task automatic cyc();
    logic [63:0] ed, es;
    logic [3:0]  ev;
    bit          er;
    int          s;
    #1;
    s  = int'(bus.in_sel);
    er = rst_n && (!mv[s] || bus.out_ready[s]);
    chk("in_ready", {63'b0, bus.in_ready}, {63'b0, er});
    last_acc = bus.in_valid && er;
    if (!rst_n) model_reset();
    else begin
      for (int i = 0; i < 4; i++)
        if (mv[i] && bus.out_ready[i]) mv[i] = 1'b0;
      if (last_acc) begin
        mv[s] = 1'b1;
        md[s] = bus.in_data;
        mc[s] = mc[s] + 16'd1;
      end
    end
    @(posedge clk);
    #1;
    ed = '0; es = '0; ev = '0;
    for (int i = 0; i < 4; i++) begin
      ev[i]          = mv[i];
      ed[16*i +: 16] = md[i];
`ifdef DMUX16_STATS_EN
      es[16*i +: 16] = mc[i];
`endif
    end
    chk("out_valid", {60'b0, bus.out_valid}, {60'b0, ev});
    chk("out_data", bus.out_data, ed);
    chk("stat_cnt", bus.stat_cnt, es);
  endtask

  task automatic drive(input bit v, input logic [1:0] s, input logic [15:0] d);
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_data  = d;
  endtask

  initial begin
    bit pend;
    model_reset();
    last_acc      = 1'b0;
    rst_n         = 1'b0;
    bus.out_ready = 4'b0000;
    drive(1'b1, 2'd0, 16'hFFFF);
    @(posedge clk);
    #1;

    // Reset held two cycles with a valid word presented.
    cyc();
    cyc();
    chk("rst_ready", {63'b0, bus.in_ready}, 64'd0);
    chk("rst_valid", {60'b0, bus.out_valid}, 64'd0);
    chk("rst_data", bus.out_data, 64'd0);
    chk("rst_stat", bus.stat_cnt, 64'd0);
    rst_n = 1'b1;

    // Basic routing with all consumers ready.
    bus.out_ready = 4'b1111;
    drive(1'b1, 2'd2, 16'h1234);
    cyc();
    chk("route_ch2", {48'b0, bus.out_data[47:32]}, 64'h1234);
    chk("route_v2", {63'b0, bus.out_valid[2]}, 64'd1);
    drive(1'b1, 2'd0, 16'h9876);
    cyc();
    chk("route_ch0", {48'b0, bus.out_data[15:0]}, 64'h9876);
    drive(1'b0, 2'd0, 16'h0000);
    cyc();

    // Backpressure on channel 1.
    bus.out_ready = 4'b0000;
    drive(1'b1, 2'd1, 16'hAAAA);
    cyc();
    chk("bp_first_acc", {63'b0, last_acc}, 64'd1);
    drive(1'b1, 2'd1, 16'h5555);
    #1;
    chk("bp_blocked", {63'b0, bus.in_ready}, 64'd0);
    cyc();
    chk("bp_hold_ch1", {48'b0, bus.out_data[31:16]}, 64'hAAAA);
    bus.out_ready = 4'b0010;
    #1;
    chk("bp_release", {63'b0, bus.in_ready}, 64'd1);
    cyc();
    chk("bp_ch1", {48'b0, bus.out_data[31:16]}, 64'h5555);
    chk("bp_v1", {63'b0, bus.out_valid[1]}, 64'd1);

    // Back-to-back loads on channel 3 with its consumer always ready.
    bus.out_ready = 4'b1111;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 2'd3, 16'(i));
      cyc();
      chk("b2b_v3", {63'b0, bus.out_valid[3]}, 64'd1);
      chk("b2b_ch3", {48'b0, bus.out_data[63:48]}, 64'(i));
    end

    // Reset while channel 0 holds an unconsumed word.
    bus.out_ready = 4'b0000;
    drive(1'b1, 2'd0, 16'hBEEF);
    cyc();
    chk("mid_ch0", {48'b0, bus.out_data[15:0]}, 64'hBEEF);
    drive(1'b0, 2'd0, 16'h0000);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("mid_v0", {63'b0, bus.out_valid[0]}, 64'd0);
    chk("mid_d0", {48'b0, bus.out_data[15:0]}, 64'd0);

`ifdef DMUX16_STATS_EN
    // Counter wrap on channel 1.
    bus.out_ready = 4'b1111;
    for (int i = 0; i < 65534; i++) begin
      drive(1'b1, 2'd1, 16'(i));
      cyc();
    end
    chk("stat_pre", {48'b0, bus.stat_cnt[31:16]}, 64'hFFFE);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd1, 16'hC000 + 16'(i));
      cyc();
    end
    chk("stat_wrap", {48'b0, bus.stat_cnt[31:16]}, 64'h0001);
    chk("stat_other", {bus.stat_cnt[63:32], 16'h0, bus.stat_cnt[15:0]}, 64'd0);
`endif

    // Randomized traffic; a blocked word is held stable until accepted.
    pend = 1'b0;
    for (int n = 0; n < 400; n++) begin
      rst_n         = ($urandom_range(0, 49) != 0);
      bus.out_ready = 4'($urandom);
      if (!pend)
        drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 16'($urandom));
      cyc();
      pend = bus.in_valid && !last_acc && rst_n;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop so the bench always ends on its own.
  initial begin
    #5000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
